icache_lines: RTL and testbench

Parametrised, direct-mapped instruction cache between the fetch stage and the D1 memory port. It replaces the single-window buffer with LINES independently tagged lines of LINE_WORDS words. Each line is filled by one incrementing word burst on D1, and bus errors are reported to the pipeline. A hit returns the instruction one cycle after IP is presented.

---
 rtl/mmu_pkg.sv | 28 ++
 rtl/icache_tag_array.sv | 52 +++++
 rtl/icache_lines.sv | 155 +++++++++++++++
 tb/tb_icache_lines.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU/bus definitions: AHB-style burst and size codes plus the icache FSM state type.
package mmu_pkg;

  localparam logic [2:0] BURST_SINGLE       = 3'b000;
  localparam logic [2:0] BURST_INCR         = 3'b001;
  localparam logic [2:0] BURST_INCR4        = 3'b011;
  localparam logic [2:0] BURST_INCR8        = 3'b101;
  localparam logic [2:0] BURST_INCR16       = 3'b111;
  localparam logic [2:0] TRANSFER_SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ICACHE_RUN,
    ICACHE_REQ,
    ICACHE_FILL,
    ICACHE_ERR
  } icache_state_t;

  // Line sizes without a fixed-length code fall back to undefined-length INCR.
  function automatic logic [2:0] incr_burst(input int unsigned words);
    case (words)
      4:       return BURST_INCR4;
      8:       return BURST_INCR8;
      16:      return BURST_INCR16;
      default: return BURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag/data storage for the direct-mapped icache: one read port,
// one word-write port, a per-line invalidate and a flush-all.
module icache_tag_array #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 8,
  parameter int unsigned TAG_W      = 25,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [$clog2(LINES)-1:0]      rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(LINES)-1:0]      wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          set_valid,
  input  logic [TAG_W-1:0]              set_tag,
  input  logic                          inv_en,
  input  logic [$clog2(LINES)-1:0]      inv_index,
  input  logic                          flush
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_word}];

  // Flush has priority over a same-cycle line install.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (inv_en)    valid_q[inv_index] <= 1'b0;
      if (set_valid) valid_q[wr_index]  <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (set_valid) tag_q[wr_index] <= set_tag;
    if (wr_en)     data_q[{wr_index, wr_word}] <= wr_data;
  end

endmodule

// File: rtl/icache_lines.sv
// Direct-mapped instruction cache: LINES tagged lines of LINE_WORDS words,
// each filled by one incrementing D1 burst; bus errors pulse BUS_ERR.
module icache_lines
  import mmu_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 8,
  parameter int unsigned INSTR_SIZE = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [INSTR_SIZE-1:0] IP,
  input  logic                  IP_VALID,
  input  logic                  FLUSH,
  output logic [INSTR_SIZE-1:0] INSTR,
  output logic                  VALID,
  output logic                  BUS_ERR,
  output logic [INSTR_SIZE-1:0] D1_ADDR,
  output logic [INSTR_SIZE-1:0] D1_WRITE_DATA,
  input  logic [INSTR_SIZE-1:0] D1_READ_DATA,
  output logic                  D1_WRITE,
  output logic [2:0]            D1_SIZE,
  output logic [2:0]            D1_BURST,
  input  logic                  D1_READYOUT,
  input  logic                  D1_RESP,
  output logic                  D1_CLAIM
);

  localparam int unsigned WW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = INSTR_SIZE - 2 - WW - IW;
  localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);
  localparam logic [INSTR_SIZE-1:0] LINE_MASK =
    {{(INSTR_SIZE-WW-2){1'b0}}, {(WW+2){1'b1}}};

  icache_state_t state_q, state_d;

  logic [WW-1:0]         beat_q;
  logic [INSTR_SIZE-1:0] line_base_q;
  logic                  flushed_q;
  logic [INSTR_SIZE-1:0] instr_q;
  logic                  valid_q;

  logic                  rd_valid;
  logic [TW-1:0]         rd_tag;
  logic [INSTR_SIZE-1:0] rd_data;
  logic                  hit, lookup_hit, miss;
  logic                  fill_we, last_beat, set_valid;

  logic [IW-1:0] ip_index, fill_index;
  logic [WW-1:0] ip_word;
  logic [TW-1:0] ip_tag, fill_tag;

  assign ip_word    = IP[2 +: WW];
  assign ip_index   = IP[2+WW +: IW];
  assign ip_tag     = IP[INSTR_SIZE-1 -: TW];
  assign fill_index = line_base_q[2+WW +: IW];
  assign fill_tag   = line_base_q[INSTR_SIZE-1 -: TW];

  assign hit        = rd_valid && (rd_tag == ip_tag);
  assign lookup_hit = (state_q == ICACHE_RUN) && IP_VALID && hit;
  assign miss       = (state_q == ICACHE_RUN) && IP_VALID && !hit;
  assign last_beat  = fill_we && (beat_q == LAST_BEAT);
  assign set_valid  = last_beat && !flushed_q;

  icache_tag_array #(
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES),
    .TAG_W      (TW),
    .DATA_W     (INSTR_SIZE)
  ) u_tag_array (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .rd_index  (ip_index),
    .rd_word   (ip_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (fill_we),
    .wr_index  (fill_index),
    .wr_word   (beat_q),
    .wr_data   (D1_READ_DATA),
    .set_valid (set_valid),
    .set_tag   (fill_tag),
    .inv_en    (miss),
    .inv_index (ip_index),
    .flush     (FLUSH)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= ICACHE_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_RUN:  if (miss) state_d = ICACHE_REQ;
      ICACHE_REQ: begin
        if (D1_RESP)          state_d = ICACHE_ERR;
        else if (D1_READYOUT) state_d = ICACHE_FILL;
      end
      ICACHE_FILL: begin
        if (D1_RESP)        state_d = ICACHE_ERR;
        else if (last_beat) state_d = ICACHE_RUN;
      end
      default:     state_d = ICACHE_RUN;
    endcase
  end

  always_comb begin
    D1_CLAIM = 1'b0;
    D1_ADDR  = '0;
    D1_SIZE  = '0;
    D1_BURST = '0;
    BUS_ERR  = 1'b0;
    fill_we  = 1'b0;
    case (state_q)
      ICACHE_REQ, ICACHE_FILL: begin
        D1_CLAIM = 1'b1;
        D1_ADDR  = line_base_q;
        D1_SIZE  = TRANSFER_SIZE_WORD;
        D1_BURST = incr_burst(LINE_WORDS);
        fill_we  = (state_q == ICACHE_FILL) && D1_READYOUT && !D1_RESP;
      end
      ICACHE_ERR: BUS_ERR = 1'b1;
      default: ;
    endcase
  end

  // A flush seen while the burst is in flight keeps the refilled line invalid.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      beat_q      <= '0;
      line_base_q <= '0;
      flushed_q   <= 1'b0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= lookup_hit;
      if (lookup_hit) instr_q <= rd_data;
      if (miss) line_base_q <= IP & ~LINE_MASK;
      if (state_q == ICACHE_RUN) flushed_q <= 1'b0;
      else if (FLUSH)            flushed_q <= 1'b1;
      if (state_q != ICACHE_FILL) beat_q <= '0;
      else if (fill_we)           beat_q <= beat_q + WW'(1);
    end
  end

  assign INSTR         = instr_q;
  assign VALID         = valid_q;
  assign D1_WRITE      = 1'b0;
  assign D1_WRITE_DATA = '0;

endmodule

// File: tb/tb_icache_lines.sv
// Self-checking bench for icache_lines (LINES=8, LINE_WORDS=4): directed
// corner sequences plus a randomized run against a line-level cache model.
module tb_icache_lines;

  logic        CLK = 1'b0;
  logic        RSTN, IP_VALID, FLUSH;
  logic [31:0] IP;
  logic [31:0] INSTR, D1_ADDR, D1_WRITE_DATA, D1_READ_DATA;
  logic        VALID, BUS_ERR, D1_WRITE, D1_READYOUT, D1_RESP, D1_CLAIM;
  logic [2:0]  D1_SIZE, D1_BURST;

  icache_lines #(.LINE_WORDS(4), .LINES(8), .INSTR_SIZE(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .IP(IP), .IP_VALID(IP_VALID), .FLUSH(FLUSH),
    .INSTR(INSTR), .VALID(VALID), .BUS_ERR(BUS_ERR),
    .D1_ADDR(D1_ADDR), .D1_WRITE_DATA(D1_WRITE_DATA), .D1_READ_DATA(D1_READ_DATA),
    .D1_WRITE(D1_WRITE), .D1_SIZE(D1_SIZE), .D1_BURST(D1_BURST),
    .D1_READYOUT(D1_READYOUT), .D1_RESP(D1_RESP), .D1_CLAIM(D1_CLAIM)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus responder knobs and observations.
  int ready_pct = 100;
  int err_pct   = 0;
  int err_beat  = -1;
  int bursts    = 0;
  bit fill_done = 0;
  bit err_now   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // D1 slave: address phase, then LINE_WORDS data beats from mem_word().
  initial begin
    bit          active = 0;
    bit          data_phase = 0;
    int          cnt = 0;
    logic [31:0] base = '0;
    D1_READYOUT = 1'b0;
    D1_RESP = 1'b0;
    D1_READ_DATA = '0;
    forever begin
      @(negedge CLK);
      fill_done = 0;
      err_now = 0;
      if (!D1_CLAIM) begin
        active = 0;
        D1_READYOUT = 1'b0;
        D1_RESP = 1'b0;
      end else begin
        if (!active) begin
          active = 1;
          data_phase = 0;
          cnt = 0;
          base = D1_ADDR;
          bursts++;
          chk("burst_base_aligned", {28'h0, base[3:0]}, 32'h0);
          if (err_pct > 0)
            err_beat = ($urandom_range(0, 99) < err_pct) ? int'($urandom_range(0, 3)) : -1;
        end else begin
          chk("d1_addr_stable", D1_ADDR, base);
        end
        chk("d1_burst", {29'h0, D1_BURST}, 32'h3);
        chk("d1_size", {29'h0, D1_SIZE}, 32'h2);
        D1_READ_DATA = $urandom;
        if (!data_phase) begin
          D1_RESP = 1'b0;
          D1_READYOUT = ($urandom_range(0, 99) < ready_pct);
          if (D1_READYOUT) data_phase = 1;
        end else if (cnt == err_beat) begin
          D1_RESP = 1'b1;
          D1_READYOUT = 1'b1;
          err_now = 1;
          err_beat = -1;
        end else begin
          D1_RESP = 1'b0;
          D1_READYOUT = ($urandom_range(0, 99) < ready_pct);
          D1_READ_DATA = mem_word(base + 32'(4 * cnt));
          if (D1_READYOUT) begin
            if (cnt == 3) fill_done = 1;
            cnt++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic fetch(input logic [31:0] a, input int exp_lat, input string name);
    int n = 0;
    int b0 = bursts;
    IP = a;
    IP_VALID = 1'b1;
    do begin
      step();
      n++;
    end while (!VALID && n < 40);
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_instr"}, INSTR, mem_word(a));
    IP_VALID = 1'b0;
    chk({name, "_bursts"}, bursts - b0, (exp_lat > 1) ? 1 : 0);
    step();
  endtask

  typedef struct {
    logic [31:0] ip;
    logic        ipv;
    logic        exp_v;
    logic [31:0] exp_i;
  } vec_t;
  vec_t tbl [6];

  bit          m_ok   [8];
  logic [31:0] m_line [8];

  initial begin
    int n, b0, pulses;
    bit prev_flush, prev_claim, prev_run, claim_now, run_now, bflushed, exp_v, exp_req, hit;
    logic [31:0] exp_i, exp_base, cur_base;

    tbl[0] = '{32'h104, 1'b1, 1'b1, 32'hA000_0041};
    tbl[1] = '{32'h108, 1'b1, 1'b1, 32'hA000_0042};
    tbl[2] = '{32'h10C, 1'b1, 1'b1, 32'hA000_0043};
    tbl[3] = '{32'h100, 1'b1, 1'b1, 32'hA000_0040};
    tbl[4] = '{32'h108, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{32'h10C, 1'b1, 1'b1, 32'hA000_0043};

    RSTN = 1'b0; IP = '0; IP_VALID = 1'b0; FLUSH = 1'b0;
    step(); step();
    chk("rst_valid", VALID, 0);
    chk("rst_instr", INSTR, 0);
    chk("rst_bus_err", BUS_ERR, 0);
    chk("rst_claim", D1_CLAIM, 0);
    chk("rst_addr", D1_ADDR, 0);
    chk("rst_size", {29'h0, D1_SIZE}, 0);
    chk("rst_burst", {29'h0, D1_BURST}, 0);
    chk("d1_write", D1_WRITE, 0);
    chk("d1_wdata", D1_WRITE_DATA, 0);
    RSTN = 1'b1;
    step();

    fetch(32'h100, 7, "cold");
    for (int i = 0; i < 6; i++) begin
      IP = tbl[i].ip;
      IP_VALID = tbl[i].ipv;
      step();
      chk($sformatf("tbl%0d_valid", i), VALID, tbl[i].exp_v);
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_instr", i), INSTR, tbl[i].exp_i);
      chk($sformatf("tbl%0d_claim", i), D1_CLAIM, 0);
    end
    IP_VALID = 1'b0;
    step();

    fetch(32'h100, 1, "conf_hit");
    fetch(32'h200, 7, "conf_miss");
    fetch(32'h100, 7, "conf_evicted");

    err_beat = 2;
    IP = 32'h300; IP_VALID = 1'b1; n = 0;
    do begin
      step();
      n++;
    end while (!BUS_ERR && n < 30);
    chk("err_seen", BUS_ERR, 1);
    chk("err_lat", n, 5);
    IP_VALID = 1'b0;
    pulses = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (BUS_ERR) pulses++;
      chk("err_valid", VALID, 0);
    end
    chk("err_pulses", pulses, 1);
    chk("err_claim_off", D1_CLAIM, 0);
    fetch(32'h300, 7, "err_retry");

    b0 = bursts;
    IP = 32'h400; IP_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_valid_pre", VALID, 0);
    end
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    n = 4;
    do begin
      step();
      n++;
    end while (!VALID && n < 40);
    chk("fl_lat", n, 13);
    chk("fl_instr", INSTR, mem_word(32'h400));
    chk("fl_bursts", bursts - b0, 2);
    IP_VALID = 1'b0;
    step();

    IP = 32'h500; IP_VALID = 1'b1;
    step(); step(); step();
    chk("rf_in_fill", D1_CLAIM, 1);
    RSTN = 1'b0;
    step();
    chk("rf_claim", D1_CLAIM, 0);
    chk("rf_valid", VALID, 0);
    chk("rf_instr", INSTR, 0);
    RSTN = 1'b1; IP_VALID = 1'b0;
    step();
    fetch(32'h400, 7, "post_rst_a");
    fetch(32'h104, 7, "post_rst_b");

    // Randomized run with wait states, bus errors and flushes.
    ready_pct = 75;
    err_pct = 10;
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      m_ok[i] = 0;
      m_line[i] = '0;
    end
    prev_flush = 0; prev_claim = 0; prev_run = 1; bflushed = 0;
    exp_v = 0; exp_req = 0; exp_i = '0; exp_base = '0; cur_base = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", VALID, exp_v);
      if (exp_v) chk("rnd_instr", INSTR, exp_i);
      chk("rnd_bus_err", BUS_ERR, err_now);
      if (prev_flush)
        for (int i = 0; i < 8; i++) m_ok[i] = 0;
      if (fill_done && !bflushed) begin
        m_ok[cur_base[6:4]] = 1;
        m_line[cur_base[6:4]] = cur_base;
      end
      claim_now = D1_CLAIM;
      run_now = !D1_CLAIM && !BUS_ERR;
      if (prev_run) begin
        chk("rnd_req", claim_now, exp_req);
        if (exp_req && claim_now) chk("rnd_req_addr", D1_ADDR, exp_base);
      end
      if (claim_now && !prev_claim) begin
        cur_base = D1_ADDR;
        m_ok[cur_base[6:4]] = 0;
        bflushed = 0;
      end
      IP_VALID = ($urandom_range(0, 99) < 80);
      IP = 32'h1000 * $urandom_range(0, 3) + ($urandom_range(0, 31) << 2);
      FLUSH = ($urandom_range(0, 99) < 3);
      if (FLUSH && claim_now) bflushed = 1;
      hit = m_ok[IP[6:4]] && (m_line[IP[6:4]] == (IP & ~32'hF));
      exp_v = run_now && IP_VALID && hit;
      exp_i = mem_word(IP);
      exp_req = run_now && IP_VALID && !hit;
      exp_base = IP & ~32'hF;
      prev_run = run_now;
      prev_claim = claim_now;
      prev_flush = FLUSH;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
